// File: rtl/image_store_if.sv
// image_store_if: pixel-side bundle of the image buffer.
//   load_*  : host -> buffer raster load stream (valid/ready)
//   row/col/in_pix/out_we/out_pix : processor random-access port
//   *_done  : processor stage completion levels
//   dump_*  : buffer -> host raster result stream (valid/ready)
// Handshake rule for both streams: a beat transfers on a rising clk
// edge where valid and ready are both 1. The sender holds valid and
// data stable until that edge. Ready may change freely.
// Modports: master = host/processor side, slave = image_store.
interface image_store_if #(
  parameter int PIX_W = 24
);
  logic             load_valid;
  logic [PIX_W-1:0] load_pix;
  logic             load_ready;
  logic [5:0]       row;
  logic [5:0]       col;
  logic [PIX_W-1:0] in_pix;
  logic             out_we;
  logic [PIX_W-1:0] out_pix;
  logic             mirror_done;
  logic             gray_done;
  logic             filter_done;
  logic             dump_valid;
  logic [PIX_W-1:0] dump_pix;
  logic             dump_ready;

  modport master (
    output load_valid, load_pix, row, col, out_we, out_pix,
           mirror_done, gray_done, filter_done, dump_ready,
    input  load_ready, in_pix, dump_valid, dump_pix
  );

  modport slave (
    input  load_valid, load_pix, row, col, out_we, out_pix,
           mirror_done, gray_done, filter_done, dump_ready,
    output load_ready, in_pix, dump_valid, dump_pix
  );
endinterface

// File: rtl/image_store.sv
// image_store: in-place 64x64 RGB buffer behind the image processor.
// Phases: LOAD (host streams 4096 pixels in raster order), PROC
// (processor reads/writes by row/col, stage flags tracked), DUMP
// (buffer streamed out in raster order), then back to LOAD.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : image_store_if.slave (load/proc/dump signals)
//   phase      : 0 LOAD, 1 PROC, 2 DUMP (FSM state, also debug view)
//   stage_err  : sticky, stage completion flags arrived out of order
module image_store #(
  parameter int IMG_DIM = 64,
  parameter int PIX_W   = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  image_store_if.slave bus,
  output logic [1:0]   phase,
  output logic         stage_err
);

  localparam int DEPTH  = IMG_DIM * IMG_DIM;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_PROC = 2'd1,
    PH_DUMP = 2'd2
  } phase_t;

  phase_t state_q, state_d;

  // One extra bit so DUMP can tell "all 4096 fetched" from index 0.
  logic [ADDR_W:0]   cnt_q;
  logic [PIX_W-1:0]  mem [DEPTH];
  logic              seen_mirror_q;
  logic              seen_gray_q;

  logic              load_fire;
  logic              load_last;
  logic              dump_advance;
  logic              dump_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;

  assign load_fire = bus.load_valid && (state_q == PH_LOAD);
  assign load_last = load_fire && (cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

  // Fetch the next pixel whenever the output register is empty or being
  // drained this edge, as long as pixels remain.
  assign dump_advance = (state_q == PH_DUMP) && !cnt_q[ADDR_W] &&
                        (!bus.dump_valid || bus.dump_ready);
  // Last pixel handed over: everything fetched and final beat accepted.
  assign dump_last    = (state_q == PH_DUMP) && cnt_q[ADDR_W] &&
                        bus.dump_valid && bus.dump_ready;

  assign bus.load_ready = (state_q == PH_LOAD);
  assign bus.in_pix     = mem[{bus.row, bus.col}];
  assign phase          = state_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PH_LOAD;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_LOAD: if (load_last)       state_d = PH_PROC;
      PH_PROC: if (bus.filter_done) state_d = PH_DUMP;
      PH_DUMP: if (dump_last)       state_d = PH_LOAD;
      default:                      state_d = PH_LOAD;
    endcase
  end

  // Single write port: host load in LOAD, processor write in PROC.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cnt_q[ADDR_W-1:0];
    mem_wdata = bus.load_pix;
    if (load_fire) begin
      mem_we = 1'b1;
    end else if ((state_q == PH_PROC) && bus.out_we) begin
      mem_we    = 1'b1;
      mem_addr  = {bus.row, bus.col};
      mem_wdata = bus.out_pix;
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Raster counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        PH_LOAD: begin
          if (load_last)      cnt_q <= '0;
          else if (load_fire) cnt_q <= cnt_q + 1'b1;
        end
        PH_PROC: begin
          if (bus.filter_done) cnt_q <= '0;
        end
        PH_DUMP: begin
          if (dump_last)         cnt_q <= '0;
          else if (dump_advance) cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Dump output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dump_valid <= 1'b0;
      bus.dump_pix   <= '0;
    end else if (dump_advance) begin
      bus.dump_valid <= 1'b1;
      bus.dump_pix   <= mem[cnt_q[ADDR_W-1:0]];
    end else if (dump_last) begin
      bus.dump_valid <= 1'b0;
    end
  end

  // Stage tracking. Ordering is judged against flags seen on earlier
  // cycles. A filter flag needs no seen bit: it leaves PROC at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_mirror_q <= 1'b0;
      seen_gray_q   <= 1'b0;
      stage_err     <= 1'b0;
    end else if (state_q == PH_PROC) begin
      seen_mirror_q <= seen_mirror_q | bus.mirror_done;
      seen_gray_q   <= seen_gray_q | bus.gray_done;
      stage_err     <= stage_err |
                       (bus.gray_done && !seen_mirror_q) |
                       (bus.filter_done && !seen_gray_q);
    end else if (dump_last) begin
      seen_mirror_q <= 1'b0;
      seen_gray_q   <= 1'b0;
      stage_err     <= 1'b0;
    end
  end

endmodule
